// File: rtl/pc_seq_ctrl_pkg.sv
// Shared encodings for the PC-source sequencer: mux selects, instruction
// classes, exception vector addresses, FSM states and the latched request.
package pc_seq_ctrl_pkg;

  // PcSrc mux select encoding
  localparam logic [2:0] PCSRC_PC4    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_RS     = 3'b011;
  localparam logic [2:0] PCSRC_EPC    = 3'b100;
  localparam logic [2:0] PCSRC_VEC    = 3'b101;

  // Instruction class codes carried with a resolve request
  localparam logic [2:0] OP_SEQ = 3'b000;
  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_BNE = 3'b010;
  localparam logic [2:0] OP_BLE = 3'b011;
  localparam logic [2:0] OP_BGT = 3'b100;
  localparam logic [2:0] OP_J   = 3'b101;
  localparam logic [2:0] OP_JR  = 3'b110;
  localparam logic [2:0] OP_RTE = 3'b111;

  // Fixed memory locations holding the handler-address byte
  localparam logic [7:0] VEC_OPCODE   = 8'd253;
  localparam logic [7:0] VEC_OVERFLOW = 8'd254;
  localparam logic [7:0] VEC_DIVZERO  = 8'd255;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INC     = 3'd1;
  localparam logic [2:0] ST_RESOLVE = 3'd2;
  localparam logic [2:0] ST_EXC_EPC = 3'd3;
  localparam logic [2:0] ST_EXC_RD  = 3'd4;
  localparam logic [2:0] ST_EXC_LD  = 3'd5;

  // Request data captured when a resolve request is accepted
  typedef struct packed {
    logic [2:0] op;
    logic       zero;
    logic       gt;
    logic       exc;
    logic [7:0] addr;
  } resolve_req_t;

  // Conditional branch classes hold the branch-target select in RESOLVE
  function automatic logic is_branch(input logic [2:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLE) || (op == OP_BGT);
  endfunction

  // Branch decision for a conditional class given the ALU flags
  function automatic logic branch_taken(input logic [2:0] op, input logic zero,
                                        input logic gt);
    logic t;
    t = 1'b0;
    case (op)
      OP_BEQ:  t = zero;
      OP_BNE:  t = !zero;
      OP_BLE:  t = !gt;
      OP_BGT:  t = gt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_exc_priority_enc.sv
// Exception priority encoder: opcode > overflow > divzero. Purely combinational.
module exc_priority_enc
  import pc_seq_ctrl_pkg::*;
(
  input  logic       i_exc_opcode,
  input  logic       i_exc_overflow,
  input  logic       i_exc_divzero,
  output logic       o_valid,
  output logic [7:0] o_addr
);

  // Highest-priority pending exception selects the vector address
  always_comb begin
    o_valid = i_exc_opcode | i_exc_overflow | i_exc_divzero;
    o_addr  = 8'd0;
    if (i_exc_opcode)        o_addr = VEC_OPCODE;
    else if (i_exc_overflow) o_addr = VEC_OVERFLOW;
    else if (i_exc_divzero)  o_addr = VEC_DIVZERO;
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC-source / PC-write sequencer for the multicycle CPU. Handles fetch
// increments, end-of-execute resolution and the exception entry sequence
// (EPC save, vector byte read, PC load). All outputs decode from registered
// state and latched request data only.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       resolve_req,
  input  logic [2:0] op_class,
  input  logic       alu_zero,
  input  logic       alu_gt,
  input  logic       exc_opcode,
  input  logic       exc_overflow,
  input  logic       exc_divzero,
  output logic [2:0] PcSrc,
  output logic       PCWrite,
  output logic       EPCWrite,
  output logic       ExcMemRead,
  output logic [7:0] ExcAddr,
  output logic       busy,
  output logic       done
);

  // Last EXC_RD count value; MEM_LAT is limited to 1..7 so it fits 3 bits
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  resolve_req_t r_req;
  logic [2:0]   r_cnt;
  logic         w_exc_valid;
  logic [7:0]   w_exc_addr;

  exc_priority_enc u_exc_enc (
    .i_exc_opcode   (exc_opcode),
    .i_exc_overflow (exc_overflow),
    .i_exc_divzero  (exc_divzero),
    .o_valid        (w_exc_valid),
    .o_addr         (w_exc_addr)
  );

  // Next-state logic; requests are only looked at in IDLE (no queueing)
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (resolve_req)    w_next = ST_RESOLVE;
        else if (fetch_req) w_next = ST_INC;
      end
      ST_INC:     w_next = ST_IDLE;
      ST_RESOLVE: w_next = r_req.exc ? ST_EXC_EPC : ST_IDLE;
      ST_EXC_EPC: w_next = ST_EXC_RD;
      ST_EXC_RD:  w_next = (r_cnt == LAT_LAST) ? ST_EXC_LD : ST_EXC_RD;
      ST_EXC_LD:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State, request latch and memory-latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      // Capture the resolve payload; vector address is fixed from here on
      if (r_state == ST_IDLE && resolve_req) begin
        r_req.op   <= op_class;
        r_req.zero <= alu_zero;
        r_req.gt   <= alu_gt;
        r_req.exc  <= w_exc_valid;
        r_req.addr <= w_exc_addr;
      end else if (r_state != ST_IDLE && w_next == ST_IDLE) begin
        r_req <= '0;
      end
      // Count EXC_RD cycles, starting from zero on entry
      if (r_state == ST_EXC_RD) r_cnt <= r_cnt + 3'd1;
      else                      r_cnt <= 3'd0;
    end
  end

  // Moore output decode
  always_comb begin
    PcSrc      = PCSRC_PC4;
    PCWrite    = 1'b0;
    EPCWrite   = 1'b0;
    ExcMemRead = 1'b0;
    ExcAddr    = 8'd0;
    done       = 1'b0;
    busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_INC: begin
        PCWrite = 1'b1;
        done    = 1'b1;
      end
      ST_RESOLVE: begin
        ExcAddr = r_req.addr;
        // An exception suppresses the normal PC update and completion
        if (!r_req.exc) begin
          done = 1'b1;
          if (is_branch(r_req.op)) begin
            PcSrc   = PCSRC_BRANCH;
            PCWrite = branch_taken(r_req.op, r_req.zero, r_req.gt);
          end else begin
            case (r_req.op)
              OP_J: begin
                PcSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
              end
              OP_JR: begin
                PcSrc   = PCSRC_RS;
                PCWrite = 1'b1;
              end
              OP_RTE: begin
                PcSrc   = PCSRC_EPC;
                PCWrite = 1'b1;
              end
              default: begin
                PcSrc   = PCSRC_PC4;
                PCWrite = 1'b0;
              end
            endcase
          end
        end
      end
      ST_EXC_EPC: begin
        ExcAddr  = r_req.addr;
        EPCWrite = 1'b1;
      end
      ST_EXC_RD: begin
        ExcAddr    = r_req.addr;
        ExcMemRead = 1'b1;
      end
      ST_EXC_LD: begin
        ExcAddr = r_req.addr;
        PcSrc   = PCSRC_VEC;
        PCWrite = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Sequencer for the PC-source multiplexer and PC register write enable in the multicycle CPU. Main control hands it two kinds of request: a fetch-increment request, and an end-of-execute resolve request carrying the instruction class, ALU flags and exception flags. The block generates `PcSrc`, `PCWrite` and `EPCWrite`. For exceptions it also reads the handler-address byte from the fixed memory vector before loading the PC.

## Interface
Parameters:
- `MEM_LAT`, default 2: cycles from asserting `ExcMemRead` to vector byte valid on the mux input (range 1–7).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: one-cycle pulse requesting PC ← PC+4.
- `resolve_req` in 1: one-cycle pulse requesting end-of-instruction PC resolution.
- `op_class` in 3: sampled with `resolve_req`.
  - 000 sequential, 001 beq, 010 bne, 011 ble, 100 bgt, 101 j/jal, 110 jr, 111 rte.
- `alu_zero`, `alu_gt` in 1 each: sampled with `resolve_req`.
- `exc_opcode`, `exc_overflow`, `exc_divzero` in 1 each: sampled with `resolve_req`.
- `PcSrc` out 3: mux select.
  - 000 PC+4, 001 branch target, 010 jump target, 011 rs, 100 EPC, 101 exception vector byte.
- `PCWrite` out 1: PC register load enable.
- `EPCWrite` out 1: EPC load enable.
- `ExcMemRead` out 1: memory read strobe for the vector byte.
- `ExcAddr` out 8: vector address, 253 / 254 / 255.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the request completes.

## Operation
- All outputs are Moore outputs of registered state and latched request data. No combinational input-to-output path.
- States: IDLE, INC, RESOLVE, EXC_EPC, EXC_RD, EXC_LD.
- IDLE: all outputs 0, `PcSrc`=000.
  - `resolve_req` → latch `op_class`, flags and exception bits, go to RESOLVE.
  - Otherwise `fetch_req` → INC.
  - If both are high in the same cycle, `resolve_req` wins and `fetch_req` is dropped.
- INC: `PcSrc`=000, `PCWrite`=1, `done`=1 → IDLE.
- RESOLVE with any latched exception → EXC_EPC, with `PCWrite`=0. Otherwise `done`=1, then IDLE, with the PC update set by class:
  - Sequential: `PCWrite`=0.
  - beq: `PcSrc`=001, `PCWrite`=`alu_zero`.
  - bne: `PcSrc`=001, `PCWrite`=!`alu_zero`.
  - ble: `PcSrc`=001, `PCWrite`=!`alu_gt`.
  - bgt: `PcSrc`=001, `PCWrite`=`alu_gt`.
  - j/jal: `PcSrc`=010, `PCWrite`=1.
  - jr: `PcSrc`=011, `PCWrite`=1.
  - rte: `PcSrc`=100, `PCWrite`=1.
- Exception priority: opcode (253) > overflow (254) > divzero (255). `ExcAddr` is fixed when RESOLVE is entered and held until IDLE.
- EXC_EPC: `EPCWrite`=1 for one cycle → EXC_RD.
- EXC_RD: `ExcMemRead`=1 for exactly `MEM_LAT` cycles, counted by a 3-bit counter → EXC_LD.
- EXC_LD: `PcSrc`=101, `PCWrite`=1, `done`=1 → IDLE.
- `PcSrc` returns to 000 in every cycle where `PCWrite`=0, except RESOLVE for branch classes, which holds 001.
- Requests arriving while `busy`=1 are ignored. They are not queued.

## Timing
- Reset: state IDLE, latches and counter cleared, every output 0 (including `PcSrc`=000 and `ExcAddr`=0), effective the cycle after `reset` is sampled high.
- Reset mid-sequence (any state) aborts the sequence: no further `PCWrite`/`EPCWrite`, pending exception discarded.
- Fetch latency: request at edge N → `PCWrite` high during cycle N+1.
- Resolve latency, no exception: `done` during cycle N+1.
- Exception path:
  - `EPCWrite` at N+2.
  - `ExcMemRead` at N+3 … N+2+`MEM_LAT`.
  - `PCWrite`/`done` at N+3+`MEM_LAT`.
  - With the default parameter: N+5. `busy` stays high throughout.
- Back-to-back: a new request may be sampled in the cycle IDLE is re-entered, i.e. the cycle after `done`.

## Structure
- Shared package holds:
  - `PcSrc` encoding constants (000–101).
  - `op_class` codes.
  - Vector addresses 253/254/255.
  - State encoding.
- One sub-module, `exc_priority_enc`: three exception bits in → valid flag and 8-bit vector address out, purely combinational.
- The FSM, latches and latency counter live in `pc_seq_ctrl`.

## Test plan
- Reset → IDLE, then `fetch_req` pulse → next cycle `PcSrc`=000, `PCWrite`=1, `done`=1; the cycle after, all outputs 0.
- `resolve_req` with beq: `alu_zero`=1 → `PcSrc`=001, `PCWrite`=1. Repeat with `alu_zero`=0 → `PCWrite`=0, `done`=1.
- `resolve_req` with jr, then rte → `PcSrc`=011 then 100, `PCWrite`=1 each, one cycle after each request.
- `resolve_req` with `exc_overflow`=1 and `exc_divzero`=1 → `ExcAddr`=254, expected sequence (default parameter):
  - `EPCWrite` at N+2.
  - `ExcMemRead` high for 2 cycles.
  - `PcSrc`=101 with `PCWrite`=1 at N+5.
- `fetch_req` and `resolve_req` in the same cycle → only the resolve response. `fetch_req` during an exception sequence → ignored, no extra `PCWrite`.
- `reset` asserted during EXC_RD → next cycle IDLE with all outputs 0, and no `PCWrite` ever appears for the aborted sequence.
